// File: rtl/edge_detector_multi.sv
`default_nettype none
// ============================================================================
//  Module   : edge_detector_multi
//  Brief    : N-channel edge detector. Each channel has an input synchroniser,
//             a glitch filter, a Moore edge FSM, a per-channel mode
//             (off/rise/fall/both), a registered one-cycle tick and a
//             saturating event counter with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_detector_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       sig,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       clr,
    output logic [N-1:0]       lvl,
    output logic [N-1:0]       tick,
    output logic [N*CNT_W-1:0] evt_cnt
);

    // Filter counter must hold 0..FILTER_LEN-1; one extra bit keeps it >=1 wide.
    localparam int c_FC_W = $clog2(FILTER_LEN) + 1;
    localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    // Edge FSM encoding
    localparam logic [1:0] c_ST_LOW  = 2'd0;
    localparam logic [1:0] c_ST_RISE = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;
    localparam logic [1:0] c_ST_FALL = 2'd3;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_FC_W-1:0]      r_fc;
        logic                   r_lvl;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic                   w_tick_nxt;
        logic                   r_tick;
        logic [CNT_W-1:0]       r_cnt;
        logic [1:0]             w_mode;
        logic                   w_sync;

        assign w_mode = mode[2*i +: 2];
        assign w_sync = r_sync[SYNC_STAGES-1];

        // Shift the asynchronous pin through the synchroniser chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], sig[i]};
            end
        end

        // Accept a level change only after FILTER_LEN consecutive differing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_fc  <= '0;
                r_lvl <= 1'b0;
            end else if (w_sync == r_lvl) begin
                r_fc <= '0;
            end else if (r_fc == c_FC_LAST) begin
                r_lvl <= w_sync;
                r_fc  <= '0;
            end else begin
                r_fc <= r_fc + c_FC_W'(1);
            end
        end

        // Edge FSM state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_ST_LOW;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Next state from the filtered level; tick qualified by the mode
        // present at the edge that enters RISE/FALL.
        always_comb begin
            w_state_nxt = r_state;
            w_tick_nxt  = 1'b0;
            case (r_state)
                c_ST_LOW:  w_state_nxt = r_lvl ? c_ST_RISE : c_ST_LOW;
                c_ST_RISE: w_state_nxt = r_lvl ? c_ST_HIGH : c_ST_FALL;
                c_ST_HIGH: w_state_nxt = r_lvl ? c_ST_HIGH : c_ST_FALL;
                c_ST_FALL: w_state_nxt = r_lvl ? c_ST_RISE : c_ST_LOW;
                default:   w_state_nxt = c_ST_LOW;
            endcase
            w_tick_nxt = ((w_state_nxt == c_ST_RISE) && w_mode[0]) ||
                         ((w_state_nxt == c_ST_FALL) && w_mode[1]);
        end

        // Registered tick, aligned with the cycle the FSM sits in RISE/FALL.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_tick_nxt;
            end
        end

        // Saturating event counter; a clear coinciding with an event keeps that event.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (clr[i]) begin
                r_cnt <= w_tick_nxt ? CNT_W'(1) : '0;
            end else if (w_tick_nxt && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign lvl[i]                   = r_lvl;
        assign tick[i]                  = r_tick;
        assign evt_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_detector_multi
//  Brief    : Directed self-checking bench for edge_detector_multi. Three
//             instances: defaults, FILTER_LEN=3, CNT_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detector_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  sig_a = '0, clr_a = '0, lvl_a, tick_a;
    logic [7:0]  mode_a = '0;
    logic [31:0] cnt_a;

    logic [3:0]  sig_b = '0, clr_b = '0, lvl_b, tick_b;
    logic [7:0]  mode_b = '0;
    logic [31:0] cnt_b;

    logic [3:0]  sig_c = '0, clr_c = '0, lvl_c, tick_c;
    logic [7:0]  mode_c = '0;
    logic [7:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_detector_multi dut_a (
        .clk(clk), .rst(rst), .sig(sig_a), .mode(mode_a), .clr(clr_a),
        .lvl(lvl_a), .tick(tick_a), .evt_cnt(cnt_a)
    );

    edge_detector_multi #(.FILTER_LEN(3)) dut_b (
        .clk(clk), .rst(rst), .sig(sig_b), .mode(mode_b), .clr(clr_b),
        .lvl(lvl_b), .tick(tick_b), .evt_cnt(cnt_b)
    );

    edge_detector_multi #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .sig(sig_c), .mode(mode_c), .clr(clr_c),
        .lvl(lvl_c), .tick(tick_c), .evt_cnt(cnt_c)
    );

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (lvl_a !== 4'h0 || tick_a !== 4'h0 || cnt_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: lvl=%h tick=%h cnt=%h, want 0/0/0", lvl_a, tick_a, cnt_a);
        end
        checks++;
        if (lvl_b !== 4'h0 || tick_b !== 4'h0 || cnt_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: lvl=%h tick=%h cnt=%h, want 0/0/0", lvl_b, tick_b, cnt_b);
        end
        checks++;
        if (lvl_c !== 4'h0 || tick_c !== 4'h0 || cnt_c !== 8'h0) begin
            errors++;
            $display("FAIL reset_c: lvl=%h tick=%h cnt=%h, want 0/0/0", lvl_c, tick_c, cnt_c);
        end
        rst = 1'b0;
        step();
    endtask

    // Channel 0 rise-only; E0 is the first edge sampling the new level.
    task automatic test_rise();
        mode_a[1:0] = 2'b01;
        sig_a[0] = 1'b1;
        step();            // E0
        step();            // E1
        checks++;
        if (lvl_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_lvl_e1: got %b want 0", lvl_a[0]);
        end
        step();            // E2
        checks++;
        if (lvl_a[0] !== 1'b1 || tick_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_e2: lvl=%b tick=%b want 1/0", lvl_a[0], tick_a[0]);
        end
        step();            // E3
        checks++;
        if (tick_a[0] !== 1'b1 || cnt_a[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL rise_e3: tick=%b cnt=%0d want 1/1", tick_a[0], cnt_a[7:0]);
        end
        step();            // E4
        checks++;
        if (tick_a[0] !== 1'b0 || cnt_a[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL rise_e4: tick=%b cnt=%0d want 0/1", tick_a[0], cnt_a[7:0]);
        end
    endtask

    // Channel 1: 8-cycle pulse, fall-only then both.
    task automatic test_fall_both();
        int n;
        int first;
        int last;
        for (int pass = 0; pass < 2; pass++) begin
            mode_a[3:2] = (pass == 0) ? 2'b10 : 2'b11;
            n = 0; first = -1; last = -1;
            sig_a[1] = 1'b1;
            for (int c = 0; c < 24; c++) begin
                if (c == 8) sig_a[1] = 1'b0;
                step();
                if (tick_a[1] === 1'b1) begin
                    n++;
                    if (first < 0) first = c;
                    last = c;
                end
            end
            if (pass == 0) begin
                checks++;
                if (n !== 1 || first !== 11 || cnt_a[15:8] !== 8'd1) begin
                    errors++;
                    $display("FAIL fall_only: ticks=%0d at=%0d cnt=%0d want 1/11/1", n, first, cnt_a[15:8]);
                end
            end else begin
                checks++;
                if (n !== 2 || first !== 3 || last !== 11 || cnt_a[15:8] !== 8'd3) begin
                    errors++;
                    $display("FAIL both: ticks=%0d at=%0d,%0d cnt=%0d want 2/3,11/3", n, first, last, cnt_a[15:8]);
                end
            end
        end
    endtask

    // FILTER_LEN=3 instance, channel 2.
    task automatic test_filter();
        mode_b[5:4] = 2'b01;
        sig_b[2] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) sig_b[2] = 1'b0;
            step();
            checks++;
            if (lvl_b[2] !== 1'b0 || tick_b[2] !== 1'b0) begin
                errors++;
                $display("FAIL filter_glitch c=%0d: lvl=%b tick=%b want 0/0", c, lvl_b[2], tick_b[2]);
            end
        end
        checks++;
        if (cnt_b[23:16] !== 8'd0) begin
            errors++;
            $display("FAIL filter_glitch_cnt: got %0d want 0", cnt_b[23:16]);
        end
        sig_b[2] = 1'b1;
        step(); step(); step(); step();   // E0..E3
        checks++;
        if (lvl_b[2] !== 1'b0) begin
            errors++;
            $display("FAIL filter_e3: lvl=%b want 0", lvl_b[2]);
        end
        step();                           // E4
        checks++;
        if (lvl_b[2] !== 1'b1 || tick_b[2] !== 1'b0) begin
            errors++;
            $display("FAIL filter_e4: lvl=%b tick=%b want 1/0", lvl_b[2], tick_b[2]);
        end
        step();                           // E5
        checks++;
        if (tick_b[2] !== 1'b1 || cnt_b[23:16] !== 8'd1) begin
            errors++;
            $display("FAIL filter_e5: tick=%b cnt=%0d want 1/1", tick_b[2], cnt_b[23:16]);
        end
        step();                           // E6
        checks++;
        if (tick_b[2] !== 1'b0) begin
            errors++;
            $display("FAIL filter_e6: tick=%b want 0", tick_b[2]);
        end
    endtask

    // CNT_W=2 instance, channel 3: saturation and clear-with-event.
    task automatic test_saturate();
        mode_c[7:6] = 2'b01;
        for (int r = 0; r < 5; r++) begin
            sig_c[3] = 1'b1;
            repeat (5) step();
            sig_c[3] = 1'b0;
            repeat (5) step();
        end
        checks++;
        if (cnt_c[7:6] !== 2'd3) begin
            errors++;
            $display("FAIL saturate: got %0d want 3", cnt_c[7:6]);
        end
        sig_c[3] = 1'b1;
        step(); step(); step();           // E0..E2
        clr_c[3] = 1'b1;
        step();                           // E3: event and clear together
        clr_c[3] = 1'b0;
        checks++;
        if (tick_c[3] !== 1'b1 || cnt_c[7:6] !== 2'd1) begin
            errors++;
            $display("FAIL clr_with_event: tick=%b cnt=%0d want 1/1", tick_c[3], cnt_c[7:6]);
        end
        step();
        clr_c[3] = 1'b1;
        step();
        clr_c[3] = 1'b0;
        checks++;
        if (cnt_c[7:6] !== 2'd0) begin
            errors++;
            $display("FAIL clr_alone: got %0d want 0", cnt_c[7:6]);
        end
    endtask

    // Mid-operation reset with sig[0] held high.
    task automatic test_reset_mid();
        sig_a[0] = 1'b0;
        repeat (6) step();
        sig_a[0] = 1'b1;
        repeat (6) step();
        checks++;
        if (cnt_a[7:0] !== 8'd2 || lvl_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d lvl=%b want 2/1", cnt_a[7:0], lvl_a[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (lvl_a !== 4'h0 || tick_a !== 4'h0 || cnt_a !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: lvl=%h tick=%h cnt=%h want 0/0/0", lvl_a, tick_a, cnt_a);
        end
        step(); step(); step();           // E0..E2
        checks++;
        if (tick_a[0] !== 1'b0 || lvl_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_e2: tick=%b lvl=%b want 0/1", tick_a[0], lvl_a[0]);
        end
        step();                           // E3
        checks++;
        if (tick_a[0] !== 1'b1 || cnt_a[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_e3: tick=%b cnt=%0d want 1/1", tick_a[0], cnt_a[7:0]);
        end
        step();                           // E4
        checks++;
        if (tick_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_e4: tick=%b want 0", tick_a[0]);
        end
    endtask

    // Channel 1 mode 11, sig toggling every cycle: a tick in every cycle.
    task automatic test_back_to_back();
        logic exp;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) sig_a[1] = (c % 2 == 0);
            step();
            exp = (c >= 3 && c <= 8);
            checks++;
            if (tick_a[1] !== exp) begin
                errors++;
                $display("FAIL b2b_tick c=%0d: got %b want %b", c, tick_a[1], exp);
            end
        end
        checks++;
        if (cnt_a[15:8] !== 8'd6) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d want 6", cnt_a[15:8]);
        end
    endtask

    // All modes off, random pins: lvl tracks with 2-cycle latency, nothing counts.
    task automatic test_mode_off();
        logic [3:0] h0, h1, h2, nv;
        mode_a = '0;
        sig_a  = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        h0 = '0; h1 = '0; h2 = '0;
        for (int c = 0; c < 40; c++) begin
            nv = 4'($urandom_range(0, 15));
            sig_a = nv;
            step();
            h2 = h1; h1 = h0; h0 = nv;
            checks++;
            if (lvl_a !== h2 || tick_a !== 4'h0 || cnt_a !== 32'h0) begin
                errors++;
                $display("FAIL mode_off c=%0d: lvl=%h tick=%h cnt=%h want %h/0/0", c, lvl_a, tick_a, cnt_a, h2);
            end
        end
    endtask

    initial begin
        step();
        test_reset();
        test_rise();
        test_fall_both();
        test_filter();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_mode_off();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
